// File: rtl/demux_dispatch_seq.sv
// Feeder for the 1-to-16 demux: FIFO-buffered {data, sel} words presented as registered v/s beats.
// Optional broadcast replay of one word to every select is enabled by defining DEMUX_DISPATCH_BCAST_EN.
module demux_dispatch_seq #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic                       in_bcast,
  output logic [WIDTH-1:0]           v,
  output logic [SEL_W-1:0]           s,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = 1 + SEL_W + WIDTH;

`ifdef DEMUX_DISPATCH_BCAST_EN
  localparam logic BC_EN = 1'b1;
`else
  localparam logic BC_EN = 1'b0;
`endif

  // Handshakes: a transfer occurs on a rising edge where valid && ready are both high;
  // a producer holding valid keeps its payload stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, BCAST = 2'd2} state_t;

  state_t             state;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               head_bc;
  logic [SEL_W-1:0]   head_sel;
  logic [WIDTH-1:0]   head_data;
  logic               push;
  logic               pop;
  logic               last_beat;

  assign in_ready = (level != LVL_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign {head_bc, head_sel, head_data} = mem[rd_ptr];
  assign busy     = (level != '0) || out_valid;

`ifdef DEMUX_DISPATCH_BCAST_EN
  logic [SEL_W-1:0] bc;
  assign last_beat = (state == SEND) || ((state == BCAST) && (&bc));
`else
  logic unused_head_bc;
  assign unused_head_bc = head_bc;
  assign last_beat      = (state == SEND);
`endif

  // A pop loads the output registers, either from IDLE or as the final beat completes.
  assign pop = (level != '0) && ((state == IDLE) || (out_ready && last_beat));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_bcast & BC_EN, in_sel, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      state     <= IDLE;
      v         <= '0;
      s         <= '0;
      out_valid <= 1'b0;
`ifdef DEMUX_DISPATCH_BCAST_EN
      bc        <= '0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (pop) begin
        v         <= head_data;
        out_valid <= 1'b1;
`ifdef DEMUX_DISPATCH_BCAST_EN
        if (head_bc) begin
          s     <= '0;
          bc    <= '0;
          state <= BCAST;
        end else begin
          s     <= head_sel;
          state <= SEND;
        end
`else
        s     <= head_sel;
        state <= SEND;
`endif
      end else if (out_valid && out_ready) begin
`ifdef DEMUX_DISPATCH_BCAST_EN
        if ((state == BCAST) && !(&bc)) begin
          bc <= bc + SEL_W'(1);
          s  <= s + SEL_W'(1);
        end else begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
`else
        state     <= IDLE;
        out_valid <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_demux_dispatch_seq.sv
// Bench for demux_dispatch_seq: vector table, directed corner sequences and a beat scoreboard.
module tb_demux_dispatch_seq;

  localparam int WIDTH = 16;
  localparam int SEL_W = 4;
  localparam int DEPTH = 4;
  localparam int NSEL  = 1 << SEL_W;
  localparam int EW    = SEL_W + WIDTH;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SEL_W-1:0] in_sel;
  logic             in_bcast;
  logic [WIDTH-1:0] v;
  logic [SEL_W-1:0] s;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [2:0]       level;

  demux_dispatch_seq #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast), .v(v), .s(s),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .level(level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DEMUX_DISPATCH_BCAST_EN
  localparam bit BC_ON = 1'b1;
`else
  localparam bit BC_ON = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] exp_v;
    logic [SEL_W-1:0] exp_s;
  } vec_t;

  vec_t              vecs[6];
  logic [EW-1:0]     exp_q[$];
  int                checks = 0;
  int                passed = 0;
  int                beats  = 0;
  int                pushes = 0;
  bit                model_on = 1'b0;
  int                m_level;
  bit                m_ov;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboard: record pushes and consume beats observed just before the edge
  task automatic cycle();
    bit pm, qm;
    logic [EW-1:0] got;
    if (in_valid && in_ready) begin
      pushes++;
      if (BC_ON && in_bcast)
        for (int i = 0; i < NSEL; i++) exp_q.push_back({SEL_W'(i), in_data});
      else
        exp_q.push_back({in_sel, in_data});
    end
    if (out_valid && out_ready) begin
      beats++;
      got = {s, v};
      if (exp_q.size() == 0) check("unexpected_beat", {12'h0, got}, 32'h0);
      else check("beat", {12'h0, got}, {12'h0, exp_q.pop_front()});
    end
    pm = 1'b0;
    qm = 1'b0;
    if (model_on) begin
      check("model_in_ready", 32'(in_ready), 32'(m_level != DEPTH));
      pm = in_valid && (m_level != DEPTH);
      qm = (m_level != 0) && (!m_ov || out_ready);
      m_level = m_level + int'(pm) - int'(qm);
      if (qm) m_ov = 1'b1;
      else if (m_ov && out_ready) m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    if (model_on) begin
      check("model_level", 32'(level), 32'(m_level));
      check("model_out_valid", 32'(out_valid), 32'(m_ov));
    end
  endtask

  task automatic drive(input logic val, input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] sl,
                       input logic bcst);
    in_valid = val;
    in_data  = d;
    in_sel   = sl;
    in_bcast = bcst;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_v"}, 32'(v), 32'h0);
    check({tag, "_s"}, 32'(s), 32'h0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_level"}, 32'(level), 32'h0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'h1);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      cycle();
      n++;
    end
    check("drain_timeout", 32'(busy), 32'h0);
  endtask

  initial begin
    int b0;
    int n;
    vecs[0] = '{16'hFFFF, 4'd5, 16'hFFFF, 4'd5};
    vecs[1] = '{16'h0000, 4'd0, 16'h0000, 4'd0};
    vecs[2] = '{16'h1234, 4'd7, 16'h1234, 4'd7};
    vecs[3] = '{16'h8001, 4'hF, 16'h8001, 4'hF};
    vecs[4] = '{16'h5A5A, 4'hA, 16'h5A5A, 4'hA};
    vecs[5].data = 16'($urandom_range(0, 16'hFFFF));
    vecs[5].sel  = 4'($urandom_range(0, 15));
    vecs[5].exp_v = vecs[5].data;
    vecs[5].exp_s = vecs[5].sel;

    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    check_reset_values("idle");

    // single-word latency table
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].data, vecs[i].sel, 1'b0);
      check("tbl_in_ready", 32'(in_ready), 32'h1);
      cycle();
      drive(1'b0, '0, '0, 1'b0);
      check("tbl_level_n", 32'(level), 32'h1);
      check("tbl_ov_n", 32'(out_valid), 32'h0);
      check("tbl_busy_n", 32'(busy), 32'h1);
      cycle();
      check("tbl_ov_n1", 32'(out_valid), 32'h1);
      check("tbl_v", 32'(v), 32'(vecs[i].exp_v));
      check("tbl_s", 32'(s), 32'(vecs[i].exp_s));
      check("tbl_level_n1", 32'(level), 32'h0);
      cycle();
      check("tbl_ov_n2", 32'(out_valid), 32'h0);
      check("tbl_busy_n2", 32'(busy), 32'h0);
    end

    // fill under backpressure: one word parks in v/s, four fill the FIFO
    out_ready = 1'b0;
    pushes = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'($urandom_range(0, 16'hFFFF)), SEL_W'(i), 1'b0);
      cycle();
    end
    check("fill_accepted", 32'(pushes), 32'd5);
    check("fill_level", 32'(level), 32'd4);
    check("fill_in_ready", 32'(in_ready), 32'h0);
    check("fill_head_s", 32'(s), 32'h0);
    drive(1'b1, 16'hDEAD, 4'd5, 1'b0);
    out_ready = 1'b1;
    check("full_pop_refuses_push", 32'(in_ready), 32'h0);
    cycle();
    drive(1'b0, '0, '0, 1'b0);
    for (int k = 1; k < 5; k++) begin
      check("fill_no_bubble", 32'(out_valid), 32'h1);
      check("fill_order_s", 32'(s), 32'(k));
      cycle();
    end
    check("fill_done_ov", 32'(out_valid), 32'h0);
    check("fill_pushes_total", 32'(pushes), 32'd5);

    // backpressure stability
    out_ready = 1'b0;
    drive(1'b1, 16'h1234, 4'd7, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      check("bp_ov", 32'(out_valid), 32'h1);
      check("bp_v", 32'(v), 32'h1234);
      check("bp_s", 32'(s), 32'h7);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    check("bp_released", 32'(out_valid), 32'h0);

    // broadcast word
    b0 = beats;
    drive(1'b1, 16'hA5A5, 4'd3, 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b0);
    drain(40);
    check("bcast_beats", 32'(beats - b0), BC_ON ? 32'(NSEL) : 32'd1);
    check("bcast_sb_empty", 32'(exp_q.size()), 32'h0);

    // reset while a beat is pending with two words queued
    out_ready = BC_ON;
    drive(1'b1, 16'hA5A5, 4'd2, 1'b1);
    cycle();
    drive(1'b1, 16'h1111, 4'd1, 1'b0);
    cycle();
    drive(1'b1, 16'h2222, 4'd2, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0);
    n = 0;
    while (!(out_valid && level == 3'd2 && (!BC_ON || s == 4'd6)) && n < 30) begin
      cycle();
      n++;
    end
    check("midop_reached", 32'(n < 30), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    b0 = beats;
    repeat (12) cycle();
    check("post_reset_beats", 32'(beats - b0), 32'h0);
    check_reset_values("post_reset");

    // concurrent traffic against a level/valid model
    m_level = 0;
    m_ov = 1'b0;
    model_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 16'($urandom_range(0, 16'hFFFF)), 4'($urandom_range(0, 15)), 1'b0);
      out_ready = (i % 2 == 0);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    drain(30);
    model_on = 1'b0;
    check("final_sb_empty", 32'(exp_q.size()), 32'h0);
    check("final_level", 32'(level), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
